// File: rtl/block_plotter.sv
// Block rasteriser: walks a BLK_W x BLK_H rectangle one pixel per clock toward
// the VGA write port, clipping off-screen pixels without changing the draw length.
module block_plotter #(
    parameter int          X_W      = 8,
    parameter int          Y_W      = 7,
    parameter int          COLOUR_W = 3,
    parameter int          BLK_W    = 4,
    parameter int          BLK_H    = 4,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [X_W-1:0]      x_in,
    input  logic [Y_W-1:0]      y_in,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic                erase,
    input  logic [COLOUR_W-1:0] bg_colour,
    output logic                busy,
    output logic                plot,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                done,
    output logic [X_W:0]        block_start,
    output logic [X_W:0]        block_end
);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    localparam logic [X_W-1:0] CX_LAST = X_W'(BLK_W - 1);
    localparam logic [Y_W-1:0] CY_LAST = Y_W'(BLK_H - 1);

    state_t              state_q, state_d;
    logic [X_W-1:0]      cx_q, cx_d, x_base_q, x_base_d, x_out_q, x_out_d;
    logic [Y_W-1:0]      cy_q, cy_d, y_base_q, y_base_d, y_out_q, y_out_d;
    logic [COLOUR_W-1:0] col_q, col_d, colour_out_q, colour_out_d;
    logic                busy_q, busy_d, plot_q, plot_d, done_q, done_d;
    logic [X_W:0]        block_start_q, block_start_d, block_end_q, block_end_d;

    logic                emit;
    logic [X_W-1:0]      e_bx;
    logic [Y_W-1:0]      e_by;
    logic [X_W:0]        x_sum;
    logic [Y_W:0]        y_sum;

    always_comb begin
        state_d       = state_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        x_base_d      = x_base_q;
        y_base_d      = y_base_q;
        col_d         = col_q;
        busy_d        = busy_q;
        plot_d        = 1'b0;
        done_d        = 1'b0;
        x_out_d       = x_out_q;
        y_out_d       = y_out_q;
        colour_out_d  = colour_out_q;
        block_start_d = block_start_q;
        block_end_d   = block_end_q;
        emit          = 1'b0;
        e_bx          = x_base_q;
        e_by          = y_base_q;

        // Counters always index the pixel being registered onto the outputs,
        // so pixel 0 is emitted on the same edge that accepts start.
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_DRAW;
                    busy_d        = 1'b1;
                    x_base_d      = x_in;
                    y_base_d      = y_in;
                    col_d         = erase ? bg_colour : colour_in;
                    block_start_d = {1'b0, x_in};
                    block_end_d   = {1'b0, x_in} + (X_W+1)'(BLK_W - 1);
                    cx_d          = '0;
                    cy_d          = '0;
                    e_bx          = x_in;
                    e_by          = y_in;
                    emit          = 1'b1;
                end
            end
            S_DRAW: begin
                if (cx_q == CX_LAST && cy_q == CY_LAST) begin
                    state_d = S_DONE;
                    cx_d    = '0;
                    cy_d    = '0;
                    done_d  = 1'b1;
                end else begin
                    if (cx_q == CX_LAST) begin
                        cx_d = '0;
                        cy_d = cy_q + 1'b1;
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                    emit = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // One extra bit keeps sums past 2^X_W distinguishable for clipping.
        x_sum = {1'b0, e_bx} + {1'b0, cx_d};
        y_sum = {1'b0, e_by} + {1'b0, cy_d};
        if (emit) begin
            x_out_d      = x_sum[X_W-1:0];
            y_out_d      = y_sum[Y_W-1:0];
            colour_out_d = col_d;
            plot_d       = (32'(x_sum) < SCREEN_W) && (32'(y_sum) < SCREEN_H);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cx_q          <= '0;
            cy_q          <= '0;
            x_base_q      <= '0;
            y_base_q      <= '0;
            col_q         <= '0;
            busy_q        <= 1'b0;
            plot_q        <= 1'b0;
            done_q        <= 1'b0;
            x_out_q       <= '0;
            y_out_q       <= '0;
            colour_out_q  <= '0;
            block_start_q <= '0;
            block_end_q   <= '0;
        end else begin
            state_q       <= state_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            x_base_q      <= x_base_d;
            y_base_q      <= y_base_d;
            col_q         <= col_d;
            busy_q        <= busy_d;
            plot_q        <= plot_d;
            done_q        <= done_d;
            x_out_q       <= x_out_d;
            y_out_q       <= y_out_d;
            colour_out_q  <= colour_out_d;
            block_start_q <= block_start_d;
            block_end_q   <= block_end_d;
        end
    end

    assign busy        = busy_q;
    assign plot        = plot_q;
    assign x_out       = x_out_q;
    assign y_out       = y_out_q;
    assign colour_out  = colour_out_q;
    assign done        = done_q;
    assign block_start = block_start_q;
    assign block_end   = block_end_q;

endmodule

// File: doc/block_plotter.md
# block_plotter

Parametrised block rasteriser for the stacker display path. It accepts a block origin, colour and mode through a start/busy handshake. It then walks a BLK_W × BLK_H rectangle one pixel per clock, driving registered x/y/colour/plot to the VGA adapter write port, and pulses done when the last pixel has been issued. It replaces the fixed 4×4 plotting datapath with configurable block size, erase mode, screen clipping and latched block extents for the game-logic collision checks.

## Interface
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COLOUR_W, 3, colour width
- BLK_W, 4, block width in pixels (1..2^X_W)
- BLK_H, 4, block height in pixels (1..2^Y_W)
- SCREEN_W, 160, visible columns; pixels with x ≥ SCREEN_W are clipped
- SCREEN_H, 120, visible rows; pixels with y ≥ SCREEN_H are clipped
- clk  in  1  system clock; one clock, all logic on rising edge
- reset  in  1  reset is synchronous and active-high
- start  in  1  request; sampled only in IDLE
- x_in  in  X_W  block origin column (left)
- y_in  in  Y_W  block origin row (top)
- colour_in  in  COLOUR_W  draw colour
- erase  in  1  sampled with start; 1 = paint bg_colour instead of colour_in
- bg_colour  in  COLOUR_W  background colour used when erasing
- busy  out  1  high in DRAW and DONE
- plot  out  1  VGA write enable for the current x_out/y_out/colour_out
- x_out  out  X_W  pixel column
- y_out  out  Y_W  pixel row
- colour_out  out  COLOUR_W  pixel colour
- done  out  1  one-cycle pulse after the last pixel
- block_start  out  X_W+1  latched left extent (zero-extended x_in)
- block_end  out  X_W+1  latched right extent, x_in + BLK_W − 1, no wrap

## Operation
- States: IDLE, DRAW, DONE.
- IDLE:
  - On start=1, latch x_base=x_in, y_base=y_in, and col = erase ? bg_colour : colour_in.
  - Load block_start and block_end.
  - Clear counters cx and cy.
  - Go to DRAW.
- DRAW, each cycle:
  - Emit the pixel (x_base+cx, y_base+cy).
  - Step cx; when cx = BLK_W−1, cx wraps to 0 and cy increments.
  - On cx=BLK_W−1 and cy=BLK_H−1, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Raster order: row-major, left to right, then top to bottom.
- Arithmetic and clipping:
  - Pixel sums are computed at X_W+1 and Y_W+1 bits.
  - x_out and y_out carry the low X_W/Y_W bits.
  - plot=0 when the extended sum ≥ SCREEN_W (x) or ≥ SCREEN_H (y), including sums past 2^X_W.
  - Clipped pixels still consume their cycle, so the draw length is fixed.
- start while busy is ignored. No queueing; the requester must wait for busy=0.
- Input changes after the start cycle have no effect on the block in flight.
- block_start and block_end hold their value until the next accepted start.

## Timing
- Reset (synchronous, any state, including mid-DRAW):
  - State = IDLE.
  - busy, plot, done = 0.
  - x_out, y_out, colour_out, block_start, block_end = 0.
  - Counters = 0.
  - The in-flight block is abandoned, with no done pulse.
- All outputs are registered.
- Let start be sampled at edge T0:
  - busy=1 and the first pixel appear after T0.
  - Pixel k (0-based) is valid in cycle k+1.
  - The last pixel is in cycle BLK_W·BLK_H.
  - done=1 in cycle BLK_W·BLK_H+1, with busy still 1 and plot=0.
  - busy=0 from cycle BLK_W·BLK_H+2.
- Earliest next start is sampled in the first cycle with busy=0. Back-to-back throughput is BLK_W·BLK_H+2 cycles per block.
- plot=0 in IDLE and DONE. Outside DRAW, x_out, y_out and colour_out hold their last values.
- BLK_W=1 or BLK_H=1 is legal: degenerate row or column, same timing formula.

## Test plan
- Defaults, start with x_in=10, y_in=20, colour_in=5, erase=0:
  - 16 plot pulses at (10..13, 20..23) in row-major order, colour 5.
  - done in cycle 17.
  - block_start=10, block_end=13.
- Erase: start with erase=1, bg_colour=0, colour_in=7 → all 16 pixels carry colour 0.
- Clipping: x_in=158, y_in=118 (defaults):
  - plot=1 only for (158..159, 118..119), 4 pulses.
  - Remaining 12 cycles have plot=0.
  - done still in cycle 17.
  - block_end=161.
- start asserted continuously and x_in changed mid-draw:
  - Second block starts exactly one cycle after busy falls.
  - The first block's pixels are unaffected.
- reset asserted at pixel 7:
  - Next cycle all outputs are 0 and state is IDLE.
  - No done pulse.
  - A following start draws a full 16-pixel block.
- Parameters BLK_W=3, BLK_H=2, x_in=255 (X_W=8):
  - Pixels 255, 0, 1 in x_out with plot=0 (sum ≥ SCREEN_W).
  - block_end=257.
  - done in cycle 7.
